// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: entry layout, port
// arbitration encoding and the word-granular address compare.
package store_buffer_pkg;

  // Width of the entry fields; the top's DATA_WIDTH must match this value.
  localparam int SB_DATA_WIDTH = 32;

  // Base of the data segment, kept here so benches and neighbours agree.
  localparam logic [SB_DATA_WIDTH-1:0] DATA_SEG_BASE = 32'h1001_0000;

  // Byte-offset bits are ignored when comparing word addresses.
  localparam logic [SB_DATA_WIDTH-1:0] WORD_MASK = ~32'h0000_0003;

  typedef struct packed {
    logic [SB_DATA_WIDTH-1:0] addr;
    logic [SB_DATA_WIDTH-1:0] data;
    logic                     valid;
  } entry_t;

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_LOAD  = 2'd1,
    PORT_DRAIN = 2'd2
  } port_sel_e;

  // True when two byte addresses fall in the same memory word.
  function automatic logic word_match(input logic [SB_DATA_WIDTH-1:0] a,
                                      input logic [SB_DATA_WIDTH-1:0] b);
    return (((a ^ b) & WORD_MASK) == {SB_DATA_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side and memory-side signals of the store buffer. The master
// side is the MEM stage plus data memory; the slave side is the buffer.
interface store_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                  st_valid_i;
  logic                  ld_valid_i;
  logic                  sync_i;
  logic [DATA_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  stall_o;
  logic [DATA_WIDTH-1:0] mem_address_o;
  logic [DATA_WIDTH-1:0] mem_write_data_o;
  logic                  mem_write_o;
  logic                  mem_read_o;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic                  empty_o;
  logic [PTR_W:0]        count_o;

  modport master (
    output st_valid_i, ld_valid_i, sync_i, addr_i, wdata_i, mem_data_i,
    input  rdata_o, stall_o, mem_address_o, mem_write_data_o,
           mem_write_o, mem_read_o, empty_o, count_o
  );

  modport slave (
    input  st_valid_i, ld_valid_i, sync_i, addr_i, wdata_i, mem_data_i,
    output rdata_o, stall_o, mem_address_o, mem_write_data_o,
           mem_write_o, mem_read_o, empty_o, count_o
  );
endinterface

// File: rtl/store_buffer_match.sv
// Youngest-match search over the buffered stores. Walks from the head
// (oldest) towards the tail so the last hit seen is the youngest one.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  entry_t [DEPTH-1:0]       entries,
  input  logic [PTR_W-1:0]         head,
  input  logic [SB_DATA_WIDTH-1:0] addr,
  output logic                     hit,
  output logic [SB_DATA_WIDTH-1:0] data
);

  logic [PTR_W-1:0] idx_s;
  logic             match_s;

  // Scan oldest to youngest; later hits overwrite earlier ones.
  always_comb begin
    hit     = 1'b0;
    data    = {SB_DATA_WIDTH{1'b0}};
    idx_s   = {PTR_W{1'b0}};
    match_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s   = head + PTR_W'(i);
      match_s = entries[idx_s].valid & word_match(entries[idx_s].addr, addr);
      hit     = hit | match_s;
      data    = match_s ? entries[idx_s].data : data;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port data memory.
// Loads own the port and are forwarded from buffered stores; stores are
// queued and drained in cycles without a load.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  entry_t [DEPTH-1:0]    entries_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W:0]        count_r;

  port_sel_e             port_sel_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fwd_hit_s;
  logic [DATA_WIDTH-1:0] fwd_data_s;

  store_buffer_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .entries (entries_r),
    .head    (rd_ptr_r),
    .addr    (sb.addr_i),
    .hit     (fwd_hit_s),
    .data    (fwd_data_s)
  );

  // Port arbitration: a load always wins, otherwise drain the head if any.
  always_comb begin
    full_s = (count_r == CNT_FULL);
    // A same-cycle pop does not make room for this cycle's store.
    push_s = sb.st_valid_i & ~full_s;
    if (sb.ld_valid_i) begin
      port_sel_s = PORT_LOAD;
    end else if (count_r != {(PTR_W + 1){1'b0}}) begin
      port_sel_s = PORT_DRAIN;
    end else begin
      port_sel_s = PORT_IDLE;
    end
    pop_s = (port_sel_s == PORT_DRAIN);
  end

  // Memory port drive according to the arbitration result.
  always_comb begin
    sb.mem_read_o       = 1'b0;
    sb.mem_write_o      = 1'b0;
    sb.mem_address_o    = {DATA_WIDTH{1'b0}};
    sb.mem_write_data_o = {DATA_WIDTH{1'b0}};
    case (port_sel_s)
      PORT_LOAD: begin
        sb.mem_read_o    = 1'b1;
        sb.mem_address_o = sb.addr_i;
      end
      PORT_DRAIN: begin
        sb.mem_write_o      = 1'b1;
        sb.mem_address_o    = entries_r[rd_ptr_r].addr;
        sb.mem_write_data_o = entries_r[rd_ptr_r].data;
      end
      default: begin
        sb.mem_read_o  = 1'b0;
        sb.mem_write_o = 1'b0;
      end
    endcase
  end

  // Load result, stall and status flags.
  always_comb begin
    if (sb.ld_valid_i) begin
      sb.rdata_o = fwd_hit_s ? fwd_data_s : sb.mem_data_i;
    end else begin
      sb.rdata_o = {DATA_WIDTH{1'b0}};
    end
    sb.stall_o = (sb.st_valid_i & full_s) |
                 (sb.sync_i & (count_r != {(PTR_W + 1){1'b0}}));
    sb.empty_o = (count_r == {(PTR_W + 1){1'b0}});
    sb.count_o = count_r;
  end

  // FIFO state: enqueue at the tail, retire the head after its drain write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_r <= '0;
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_s) begin
        entries_r[wr_ptr_r].addr  <= sb.addr_i;
        entries_r[wr_ptr_r].data  <= sb.wdata_i;
        entries_r[wr_ptr_r].valid <= 1'b1;
        wr_ptr_r                  <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        entries_r[rd_ptr_r].valid <= 1'b0;
        rd_ptr_r                  <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the MEM pipeline stage and the word-addressed data memory.
- Accepts stores into a small FIFO and drains them to memory in cycles when no load is using the single memory port.
- Loads always have port priority. They are forwarded from the youngest matching buffered store, so loads never stall.
- Decouples store traffic from loads; the sync input supports fences and end-of-test drains.

Parameters:
DATA_WIDTH, 32, data and address width
DEPTH, 4, number of buffer entries (power of 2, >=2)
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
st_valid_i  input  1  MEM stage issues a store this cycle
ld_valid_i  input  1  MEM stage issues a load this cycle
sync_i  input  1  drain request; hold pipeline until buffer empty
addr_i  input  DATA_WIDTH  byte address of load/store (data segment, e.g. 0x10010000 base)
wdata_i  input  DATA_WIDTH  store data
rdata_o  output  DATA_WIDTH  load result to MEM/WB
stall_o  output  1  freeze MEM stage and upstream this cycle
mem_address_o  output  DATA_WIDTH  address to data memory
mem_write_data_o  output  DATA_WIDTH  write data to data memory
mem_write_o  output  1  data memory write enable
mem_read_o  output  1  data memory read enable
mem_data_i  input  DATA_WIDTH  data memory read data (combinational read)
empty_o  output  1  buffer holds no entries
count_o  output  PTR_W+1  current occupancy

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state:
  - wr_ptr, rd_ptr and count are 0; all entry valid bits are cleared.
  - Outputs: stall_o=0, empty_o=1, count_o=0, mem_write_o=0, mem_read_o=0, mem_address_o=0, mem_write_data_o=0, rdata_o=0.
  - Reset mid-drain discards all pending stores; no partial write is issued.
- Entry format: {addr[DATA_WIDTH-1:0], data[DATA_WIDTH-1:0], valid}. Circular FIFO; pointers wrap DEPTH-1 -> 0.
- Port arbitration (combinational, each cycle):
  - ld_valid_i=1: mem_read_o=1, mem_write_o=0, mem_address_o=addr_i. No drain this cycle.
  - Else if count>0: mem_write_o=1, mem_read_o=0, mem_address_o=head.addr, mem_write_data_o=head.data. The head pops at the next rising edge.
  - Else: mem_write_o=0, mem_read_o=0, mem_address_o=0, mem_write_data_o=0.
- Load forwarding (zero latency):
  - Compare addr_i[DATA_WIDTH-1:2] against every valid entry; addr_i[1:0] is ignored.
  - On any match, rdata_o = data of the youngest matching entry (closest to tail).
  - On no match, rdata_o = mem_data_i.
  - With ld_valid_i=0, rdata_o=0.
- Store enqueue:
  - st_valid_i=1 and count<DEPTH: entry written at wr_ptr on the rising edge; wr_ptr++ and count++.
  - st_valid_i=1 and count==DEPTH: stall_o=1 and the store is not accepted. Upstream holds the store; it is accepted on the first cycle after a drain frees an entry.
  - No same-cycle full-bypass: a pop in the same cycle does not free space for that cycle's store.
- Simultaneous push and pop (not full): count unchanged; both pointers advance.
- Simultaneous ld_valid_i and st_valid_i: not produced by the pipeline. If it occurs, the load is served (forwarding excludes the same-cycle store), the store is enqueued, and there is no drain.
- sync_i=1: stall_o=1 while count!=0, or while a store is pending. stall_o deasserts combinationally in the cycle count==0.
- stall_o = (st_valid_i & full) | (sync_i & (count!=0)).
- empty_o = (count==0). count_o equals the registered count.
- Addresses are passed unmodified; base subtraction and word indexing stay in the memory.

Decomposition:
- Shared package holds:
  - the entry typedef (addr, data, valid);
  - DATA_SEG_BASE = 32'h10010000 (used by the bench);
  - the arbitration encoding: PORT_IDLE, PORT_LOAD, PORT_DRAIN.
- One natural sub-module: store_buffer_match, the combinational youngest-match search. Inputs are entries, the head pointer and the compare address; outputs are hit and data.
- FIFO control stays in the top module.

Test Plan:
- Reset, then store 0x10010004 <- 0xDEADBEEF on an idle port -> entry enqueued (count_o=1). Next cycle mem_write_o=1, mem_address_o=0x10010004; empty_o=1 after that edge.
- Store 0x10010008 <- 0x11111111, then store 0x10010008 <- 0x22222222 while loads are asserted back-to-back, then load 0x1001000A -> rdata_o=0x22222222 (youngest match, low bits ignored), mem_write_o=0 during the loads.
- Fill 4 stores with continuous loads, then a 5th store -> stall_o=1 and count_o=4. Drop the load -> one drain per cycle; the 5th store is accepted the cycle after the first pop; final memory contents in FIFO order.
- Load 0x10010010 with no match, mem_data_i=0xCAFEF00D -> rdata_o=0xCAFEF00D, mem_read_o=1, mem_address_o=0x10010010.
- 3 entries buffered, sync_i=1, no loads -> stall_o=1 for exactly 3 cycles, then 0 with empty_o=1.
- Assert reset asynchronously mid-drain with count_o=2 -> mem_write_o=0 immediately, count_o=0; no further writes after reset release.
